prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Write-side counterpart to the instruction ROM fetch sequencer. It accepts a stream of DEPTH instruction bytes over a valid/ready handshake and writes them to consecutive addresses of an internal DEPTH x DATA_W program RAM. It keeps a running XOR checksum and pulses done once the image is complete. A registered read port lets a fetch engine or the testbench read the image back.

Parameters:
DATA_W, 8, instruction byte width
DEPTH, 16, words per program image (power of two)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin loading an image; honoured only in IDLE
in_valid  in  1  in_data is valid this cycle
in_data  in  DATA_W  instruction byte
in_ready  out  1  loader accepts a byte this cycle; combinational, equals (state==LOAD)
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  mem[rd_addr], registered
count  out  ADDR_W+1  bytes accepted in the current or last load
checksum  out  DATA_W  XOR of bytes accepted in the current or last load
busy  out  1  high in LOAD and DONE
done  out  1  one-cycle pulse when the image is complete
err  out  1  sticky flag: in_valid was seen while not in LOAD

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, count=0, checksum=0, rd_data=0, busy=0, done=0, err=0. Memory contents are not reset.
- Handshake: a byte is accepted when in_valid && in_ready. On accept: mem[wr_ptr]<=in_data, wr_ptr+1, count+1, checksum^=in_data.
- in_data may change freely when in_valid=0. There is no back-pressure inside LOAD.
- IDLE:
  - start=1 -> LOAD next cycle.
  - Entering LOAD clears wr_ptr, count, checksum and err.
  - in_ready=0.
- LOAD:
  - in_ready=1.
  - Accepting with wr_ptr==DEPTH-1 -> DONE next cycle; wr_ptr wraps to 0.
  - Gaps of any length (in_valid=0) are allowed.
- DONE:
  - Lasts exactly one cycle; done=1 and in_ready=0, then IDLE.
  - done therefore rises the cycle after the final handshake.
- busy: registered, high in LOAD and DONE.
- start outside IDLE is ignored, with no restart.
- start in the DONE cycle is ignored; start must be reasserted in IDLE.
- err: set when in_valid=1 in IDLE or DONE (byte dropped, no write). Holds until the next start is accepted.
- Read port:
  - Usable in every state, latency 1: rd_data <= mem[rd_addr].
  - Same-cycle read and write to the same address returns the old data (read-before-write).
- count saturates naturally at DEPTH, never exceeds it, and holds until the next start.
- checksum holds its final value after DONE until the next start.
- Reset mid-LOAD: immediate return to IDLE, all registers at reset values, partially written memory is left as is.
- Width rules: count is ADDR_W+1 bits so that DEPTH is representable; wr_ptr is ADDR_W bits and wraps modulo DEPTH.

Decomposition:
- Shared package `prog_pkg`:
  - state enum (IDLE=2'b00, LOAD=2'b01, DONE=2'b10), the same encoding as the fetch sequencer
  - PROG_DEPTH=16 and INSTR_W=8 constants
- One sub-module is natural: `prog_ram_1w1r`, a DEPTH x DATA_W RAM with a synchronous write port and a registered read port.
- The loader FSM, pointer and checksum stay in prog_loader.

Test Plan:
1. Reset, start pulse, then stream A1,B2,C3,D4,E5,F6,12,34,56,78,9A,BC,DE,EF,F1,00 with in_valid held high -> in_ready high for 16 cycles; done pulses one cycle after the byte 00; count=16; checksum=F9; busy=0 two cycles after the last handshake.
2. Readback after test 1 for rd_addr 0..15 -> rd_data one cycle later equals A1..00 in order (rd_addr=5 gives F6, rd_addr=15 gives 00).
3. Same stream with in_valid toggled 1-0-1-0 -> identical memory image, checksum=F9, done only after the 16th accepted byte.
4. in_valid=1, in_data=55 while IDLE -> err=1, in_ready=0, no memory change. A subsequent start clears err and count.
5. Assert rst after 7 bytes of a load -> immediately state=IDLE, busy=0, count=0, checksum=0, done never pulses. A new start, then a full load, succeeds normally.
6. Pulse start during LOAD and again during DONE -> no restart; wr_ptr continues and done pulses exactly once. Read addr 3 in the same cycle its byte D4 is written -> rd_data returns the previous contents.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared types and constants for the program loader and the fetch sequencer.
package prog_pkg;

   localparam int PROG_DEPTH  = 16;
   localparam int INSTR_W     = 8;
   localparam int PROG_ADDR_W = $clog2(PROG_DEPTH);

   // Same encoding as the fetch sequencer so both sides decode state alike
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      DONE = 2'b10
   } prog_state_e;

endpackage

// File: rtl/prog_ram_1w1r.sv
// Program RAM: synchronous write port, registered read port (read-before-write).
module prog_ram_1w1r
   import prog_pkg::*;
#(
   parameter int DATA_W = INSTR_W,
   parameter int DEPTH  = PROG_DEPTH,
   parameter int ADDR_W = PROG_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // Contents are intentionally not reset; a partial image survives a reset
   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_rd_data <= '0;
      else       r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/prog_loader.sv
// Streams one DEPTH-byte program image into the program RAM with a running XOR checksum.
//   state | meaning
//   IDLE  | waiting for start; in_valid here is dropped and flagged in err
//   LOAD  | accepting bytes into consecutive addresses, gaps allowed
//   DONE  | single-cycle done pulse, then back to IDLE
module prog_loader
   import prog_pkg::*;
#(
   parameter int DATA_W = INSTR_W,
   parameter int DEPTH  = PROG_DEPTH,
   parameter int ADDR_W = PROG_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic [ADDR_W:0]   o_count,
   output logic [DATA_W-1:0] o_checksum,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   prog_state_e       r_state;
   prog_state_e       w_next;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_checksum;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              w_accept;
   logic              w_start_ok;
   logic              w_last;

   assign o_in_ready = (r_state == LOAD);
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_start_ok = i_start && (r_state == IDLE);
   assign w_last     = (r_wr_ptr == ADDR_W'(DEPTH - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next = LOAD;
         LOAD:    if (w_accept && w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_checksum <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == LOAD) || (w_next == DONE);
         r_done  <= (w_next == DONE);
         // A fresh start takes priority over flagging a stray byte in the same cycle
         if (w_start_ok) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_checksum <= '0;
            r_err      <= 1'b0;
         end else if (w_accept) begin
            r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
            r_count    <= r_count + (ADDR_W + 1)'(1);
            r_checksum <= r_checksum ^ i_in_data;
         end else if (i_in_valid) begin
            r_err <= 1'b1;
         end
      end
   end

   prog_ram_1w1r #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (w_accept),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_in_data),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (o_rd_data)
   );

   assign o_count    = r_count;
   assign o_checksum = r_checksum;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader against a transaction-level image model.
module tb_prog_loader;

   localparam int D = 16;

   logic       clk;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [4:0] count;
   logic [7:0] checksum;
   logic       busy;
   logic       done;
   logic       err;

   int tests  = 0;
   int failed = 0;

   logic [7:0] m_mem   [D];
   bit         m_known [D];
   logic [7:0] vec     [D] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h12, 8'h34,
                               8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hEF, 8'hF1, 8'h00};

   prog_loader dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_in_valid (in_valid),
      .i_in_data  (in_data),
      .o_in_ready (in_ready),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data),
      .o_count    (count),
      .o_checksum (checksum),
      .o_busy     (busy),
      .o_done     (done),
      .o_err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic readback();
      for (int a = 0; a < D; a++) begin
         rd_addr = 4'(a);
         step();
         if (m_known[a]) chk($sformatf("readback[%0d]", a), rd_data, m_mem[a]);
      end
   endtask

   // mode: 0 = valid every cycle, 1 = valid on alternate cycles, 2 = random gaps
   task automatic load(input int mode, input bit use_vec, input int abort_at,
                       input bit poke_start, output logic [7:0] ck);
      int         acc;
      int         cyc;
      bit         v;
      logic [7:0] b;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_ready", in_ready, 1);
      chk("start_busy", busy, 1);
      chk("start_count", count, 0);
      chk("start_cksum", checksum, 0);
      chk("start_err", err, 0);
      chk("start_done", done, 0);
      ck  = 8'h00;
      acc = 0;
      cyc = 0;
      while (acc < D && cyc < 200) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         b = use_vec ? vec[acc] : 8'($urandom);
         in_valid = v;
         in_data  = v ? b : 8'($urandom);
         rd_addr  = 4'(acc);
         start    = poke_start && (acc == 8);
         step();
         start = 1'b0;
         if (m_known[acc]) chk("read_before_write", rd_data, m_mem[acc]);
         if (v) begin
            m_mem[acc]   = b;
            m_known[acc] = 1'b1;
            ck ^= b;
            acc++;
         end
         cyc++;
         chk("count", count, acc);
         chk("cksum", checksum, ck);
         if (abort_at > 0 && acc == abort_at) begin
            in_valid = 1'b0;
            rst = 1'b1;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_ready", in_ready, 0);
            chk("rst_count", count, 0);
            chk("rst_cksum", checksum, 0);
            chk("rst_done", done, 0);
            step();
            chk("rst_rd_data", rd_data, 0);
            rst = 1'b0;
            step();
            chk("post_rst_busy", busy, 0);
            chk("post_rst_done", done, 0);
            return;
         end
         if (acc < D) begin
            chk("load_ready", in_ready, 1);
            chk("load_done", done, 0);
            chk("load_busy", busy, 1);
         end else begin
            chk("done_pulse", done, 1);
            chk("done_ready", in_ready, 0);
            chk("done_busy", busy, 1);
         end
      end
      if (acc < D) chk("load_timeout", acc, D);
      in_valid = poke_start;
      in_data  = 8'h3C;
      start    = poke_start;
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);
      chk("after_ready", in_ready, 0);
      chk("after_count", count, D);
      chk("after_cksum", checksum, ck);
      chk("after_err", err, poke_start);
      step();
      chk("no_restart_busy", busy, 0);
      chk("no_second_done", done, 0);
      chk("hold_count", count, D);
   endtask

   initial begin
      logic [7:0] ck;
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      rd_addr  = 4'h0;
      for (int i = 0; i < D; i++) m_known[i] = 1'b0;
      repeat (2) step();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_count", count, 0);
      chk("reset_cksum", checksum, 0);
      chk("reset_ready", in_ready, 0);
      chk("reset_rd_data", rd_data, 0);
      rst = 1'b0;
      step();

      // Test 1 + 2: back-to-back reference stream, then readback
      load(0, 1'b1, 0, 1'b0, ck);
      chk("t1_cksum_F9", checksum, 8'hF9);
      readback();
      rd_addr = 4'd5;
      step();
      chk("t2_addr5", rd_data, 8'hF6);
      rd_addr = 4'd15;
      step();
      chk("t2_addr15", rd_data, 8'h00);

      // Test 3: same stream with alternating valid
      load(1, 1'b1, 0, 1'b0, ck);
      chk("t3_cksum_F9", checksum, 8'hF9);
      readback();

      // Test 4: stray byte in IDLE
      in_valid = 1'b1;
      in_data  = 8'h55;
      step();
      in_valid = 1'b0;
      chk("t4_err", err, 1);
      chk("t4_ready", in_ready, 0);
      chk("t4_busy", busy, 0);
      step();
      chk("t4_err_sticky", err, 1);
      chk("t4_count_hold", count, D);
      readback();
      load(2, 1'b0, 0, 1'b0, ck);
      readback();

      // Test 5: reset after 7 bytes, then a clean full load
      load(2, 1'b0, 7, 1'b0, ck);
      readback();
      load(0, 1'b0, 0, 1'b0, ck);
      readback();

      // Test 6: start poked during LOAD and DONE, stray byte in DONE
      load(2, 1'b0, 0, 1'b1, ck);
      readback();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
